// File: rtl/fibre_mem_pkg.sv
// Shared constants and the read-pipeline stage record for the fibre-A spike-word responder.
package fibre_mem_pkg;

    localparam int DEF_TIMESTEPS    = 4;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int MAX_READ_LATENCY = 8;

    typedef struct packed {
        logic                     valid;
        logic                     oob;
        logic [DEF_TIMESTEPS-1:0] data;
    } rd_stage_t;

endpackage

// File: rtl/fibre_rd_pipe.sv
// Fixed-latency delay line for read returns; a synchronous reset flushes every stage.
module fibre_rd_pipe
    import fibre_mem_pkg::*;
#(
    parameter int  LATENCY = 2,
    parameter type stage_t = rd_stage_t
) (
    input  logic   clk,
    input  logic   rst,
    input  stage_t in_stage,
    output stage_t out_stage
);

    stage_t stages [LATENCY];

    // Clearing whole stages on reset drops in-flight reads so they never emerge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_stage;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_stage = stages[LATENCY-1];

endmodule

// File: rtl/fibre_a_mem_responder.sv
// Fibre-A read responder: spike-word register file behind a fully pipelined fixed-latency read.
// Define FIBRE_RD_STATS_EN to add the stat_reads / stat_oob counters and the stat_clr input.
module fibre_a_mem_responder
    import fibre_mem_pkg::*;
#(
    parameter int TIMESTEPS    = DEF_TIMESTEPS,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fibre_a_read_en,
    input  logic [ADDR_WIDTH-1:0] fibre_a_addr,
    output logic [TIMESTEPS-1:0]  fibre_a_data,
    output logic                  fibre_a_valid,
    output logic                  oob_err,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [TIMESTEPS-1:0]  wr_data,
    output logic [3:0]            rd_inflight
`ifdef FIBRE_RD_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [31:0]           stat_reads,
    output logic [15:0]           stat_oob
`endif
);

    typedef struct packed {
        logic                 valid;
        logic                 oob;
        logic [TIMESTEPS-1:0] data;
    } stage_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

    logic [TIMESTEPS-1:0] mem [DEPTH];
    logic                 rd_oob;
    logic                 wr_ok;
    stage_t               in_stage;
    stage_t               out_stage;
    logic [TIMESTEPS-1:0] held_data;

    assign rd_oob = {1'b0, fibre_a_addr} >= DEPTH_LIMIT;
    assign wr_ok  = {1'b0, wr_addr} < DEPTH_LIMIT;

    // No reset on the array: spike fibres must survive a TPPE restart.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        in_stage       = '0;
        in_stage.valid = fibre_a_read_en;
        in_stage.oob   = fibre_a_read_en && rd_oob;
        if (fibre_a_read_en && !rd_oob) begin
            in_stage.data = mem[fibre_a_addr];
        end
    end

    fibre_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .stage_t (stage_t)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (in_stage),
        .out_stage (out_stage)
    );

    assign fibre_a_valid = out_stage.valid;
    assign oob_err       = out_stage.valid && out_stage.oob;
    assign fibre_a_data  = out_stage.valid ? out_stage.data : held_data;

    // Keeps the last returned word visible between valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_data <= '0;
        end else if (out_stage.valid) begin
            held_data <= out_stage.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight <= '0;
        end else if (fibre_a_read_en && !fibre_a_valid) begin
            rd_inflight <= rd_inflight + 4'd1;
        end else if (!fibre_a_read_en && fibre_a_valid) begin
            rd_inflight <= rd_inflight - 4'd1;
        end
    end

`ifdef FIBRE_RD_STATS_EN
    // stat_clr wins over any increment landing on the same edge.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stat_reads <= '0;
            stat_oob   <= '0;
        end else begin
            if (fibre_a_read_en && stat_reads != '1) begin
                stat_reads <= stat_reads + 32'd1;
            end
            if (oob_err && stat_oob != '1) begin
                stat_oob <= stat_oob + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fibre_a_mem_responder.sv
// Self-checking bench for fibre_a_mem_responder: directed vector table, reset/retention sequence
// and randomized traffic against a queue-based reference model. Stats checks need FIBRE_RD_STATS_EN.
module tb_fibre_a_mem_responder;

    localparam int TS    = 4;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          fibre_a_read_en;
    logic [AW-1:0] fibre_a_addr;
    logic [TS-1:0] fibre_a_data;
    logic          fibre_a_valid;
    logic          oob_err;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [TS-1:0] wr_data;
    logic [3:0]    rd_inflight;
`ifdef FIBRE_RD_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_reads;
    logic [15:0]   stat_oob;
`endif

    always #5 clk = ~clk;

    fibre_a_mem_responder #(
        .TIMESTEPS    (TS),
        .ADDR_WIDTH   (AW),
        .DEPTH        (DEPTH),
        .READ_LATENCY (LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fibre_a_read_en (fibre_a_read_en),
        .fibre_a_addr    (fibre_a_addr),
        .fibre_a_data    (fibre_a_data),
        .fibre_a_valid   (fibre_a_valid),
        .oob_err         (oob_err),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_inflight     (rd_inflight)
`ifdef FIBRE_RD_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_reads      (stat_reads),
        .stat_oob        (stat_oob)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding reads are queued with the edge on which they must appear.
    typedef struct {
        int            due;
        logic          oob;
        logic [TS-1:0] data;
    } ret_t;

    ret_t          pend[$];
    logic [TS-1:0] ref_mem [256];
    int            cyc        = 0;
    logic          m_valid    = 1'b0;
    logic          m_oob      = 1'b0;
    logic [TS-1:0] m_data     = '0;
    int            m_inflight = 0;
    longint        m_reads    = 0;
    int            m_oobs     = 0;

    typedef struct {
        logic          r;
        logic          re;
        logic [AW-1:0] ra;
        logic          we;
        logic [AW-1:0] wa;
        logic [TS-1:0] wd;
        logic          ev;
        logic [TS-1:0] ed;
        logic          eo;
        int            ei;
    } vec_t;

    vec_t tbl[26];

    function automatic logic [TS-1:0] preVal(int a);
        logic [7:0] b;
        b = 8'(a);
        if (a == 5)  return 4'b1010;
        if (a == 8)  return 4'b1111;
        if (a == 12) return 4'b0011;
        return b[3:0] ^ b[7:4];
    endfunction

    function automatic vec_t mk(int r, int re, int ra, int we, int wa, int wd,
                                int ev, int ed, int eo, int ei);
        vec_t v;
        v.r  = (r != 0);
        v.re = (re != 0);
        v.ra = AW'(ra);
        v.we = (we != 0);
        v.wa = AW'(wa);
        v.wd = TS'(wd);
        v.ev = (ev != 0);
        v.ed = TS'(ed);
        v.eo = (eo != 0);
        v.ei = ei;
        return v;
    endfunction

    task automatic modelEdge();
        ret_t e;
        logic prev_oob_pulse;
        prev_oob_pulse = m_valid && m_oob;
        cyc++;
        if (rst) begin
            pend.delete();
            m_valid = 1'b0;
            m_oob   = 1'b0;
            m_data  = '0;
            m_reads = 0;
            m_oobs  = 0;
        end else begin
            if (fibre_a_read_en) begin
                e.due  = cyc + LAT - 1;
                e.oob  = int'(fibre_a_addr) >= DEPTH;
                e.data = e.oob ? '0 : ref_mem[fibre_a_addr];
                pend.push_back(e);
            end
            if (wr_en && int'(wr_addr) < DEPTH) begin
                ref_mem[wr_addr] = wr_data;
            end
            m_valid = 1'b0;
            m_oob   = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                e       = pend.pop_front();
                m_valid = 1'b1;
                m_oob   = e.oob;
                m_data  = e.data;
            end
`ifdef FIBRE_RD_STATS_EN
            if (stat_clr) begin
                m_reads = 0;
                m_oobs  = 0;
            end else begin
                if (fibre_a_read_en && m_reads < 64'hFFFF_FFFF) m_reads++;
                if (prev_oob_pulse && m_oobs < 65535) m_oobs++;
            end
`else
            if (prev_oob_pulse) m_oobs++;
`endif
        end
        m_inflight = pend.size() + (m_valid ? 1 : 0);
    endtask

    task automatic applyStimulus(input logic r, input logic re, input logic [AW-1:0] ra,
                                 input logic we, input logic [AW-1:0] wa, input logic [TS-1:0] wd);
        @(negedge clk);
        rst             = r;
        fibre_a_read_en = re;
        fibre_a_addr    = ra;
        wr_en           = we;
        wr_addr         = wa;
        wr_data         = wd;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [TS-1:0] ed,
                               input logic eo, input int ei);
        checks++;
        if (fibre_a_valid !== ev) begin
            errors++;
            $display("[TB] FAIL %s valid: got %0b expected %0b", name, fibre_a_valid, ev);
        end
        checks++;
        if (fibre_a_data !== ed) begin
            errors++;
            $display("[TB] FAIL %s data: got %b expected %b", name, fibre_a_data, ed);
        end
        checks++;
        if (oob_err !== eo) begin
            errors++;
            $display("[TB] FAIL %s oob_err: got %0b expected %0b", name, oob_err, eo);
        end
        checks++;
        if (rd_inflight !== 4'(ei)) begin
            errors++;
            $display("[TB] FAIL %s rd_inflight: got %0d expected %0d", name, rd_inflight, ei);
        end
    endtask

`ifdef FIBRE_RD_STATS_EN
    task automatic checkStats(input string name, input longint er, input int eo);
        checks++;
        if (stat_reads !== 32'(er)) begin
            errors++;
            $display("[TB] FAIL %s stat_reads: got %0d expected %0d", name, stat_reads, er);
        end
        checks++;
        if (stat_oob !== 16'(eo)) begin
            errors++;
            $display("[TB] FAIL %s stat_oob: got %0d expected %0d", name, stat_oob, eo);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic          r, re, we;
        logic [AW-1:0] ra, wa;
        logic [TS-1:0] wd;

        rst             = 1'b1;
        fibre_a_read_en = 1'b0;
        fibre_a_addr    = '0;
        wr_en           = 1'b0;
        wr_addr         = '0;
        wr_data         = '0;
`ifdef FIBRE_RD_STATS_EN
        stat_clr        = 1'b0;
`endif

        // Rows: rst, read_en, addr, wr_en, wr_addr, wr_data | valid, data, oob, inflight after the edge.
        tbl[0]  = mk(0, 1, 5,   0, 0,   0,  0, 0,            0, 1);
        tbl[1]  = mk(0, 0, 0,   0, 0,   0,  1, 4'b1010,      0, 1);
        tbl[2]  = mk(0, 0, 0,   0, 0,   0,  0, 4'b1010,      0, 0);
        tbl[3]  = mk(0, 1, 5,   0, 0,   0,  0, 4'b1010,      0, 1);
        tbl[4]  = mk(0, 1, 8,   0, 0,   0,  1, 4'b1010,      0, 2);
        tbl[5]  = mk(0, 1, 12,  0, 0,   0,  1, 4'b1111,      0, 2);
        tbl[6]  = mk(0, 0, 0,   0, 0,   0,  1, 4'b0011,      0, 1);
        tbl[7]  = mk(0, 0, 0,   0, 0,   0,  0, 4'b0011,      0, 0);
        tbl[8]  = mk(0, 1, 8,   1, 8,   0,  0, 4'b0011,      0, 1);
        tbl[9]  = mk(0, 1, 8,   0, 0,   0,  1, 4'b1111,      0, 2);
        tbl[10] = mk(0, 0, 0,   0, 0,   0,  1, 4'b0000,      0, 1);
        tbl[11] = mk(0, 0, 0,   0, 0,   0,  0, 4'b0000,      0, 0);
        tbl[12] = mk(0, 1, 255, 1, 255, 15, 0, 4'b0000,      0, 1);
        tbl[13] = mk(0, 1, 199, 0, 0,   0,  1, 4'b0000,      1, 2);
        tbl[14] = mk(0, 1, 200, 0, 0,   0,  1, preVal(199),  0, 2);
        tbl[15] = mk(0, 1, 55,  0, 0,   0,  1, 4'b0000,      1, 2);
        tbl[16] = mk(0, 0, 0,   0, 0,   0,  1, preVal(55),   0, 1);
        tbl[17] = mk(0, 0, 0,   0, 0,   0,  0, preVal(55),   0, 0);
        tbl[18] = mk(0, 1, 5,   0, 0,   0,  0, preVal(55),   0, 1);
        tbl[19] = mk(0, 1, 8,   0, 0,   0,  1, 4'b1010,      0, 2);
        tbl[20] = mk(1, 1, 12,  1, 5,   0,  0, 4'b0000,      0, 0);
        tbl[21] = mk(0, 0, 0,   0, 0,   0,  0, 4'b0000,      0, 0);
        tbl[22] = mk(0, 0, 0,   0, 0,   0,  0, 4'b0000,      0, 0);
        tbl[23] = mk(0, 1, 5,   0, 0,   0,  0, 4'b0000,      0, 1);
        tbl[24] = mk(0, 0, 0,   0, 0,   0,  1, 4'b1010,      0, 1);
        tbl[25] = mk(0, 0, 0,   0, 0,   0,  0, 4'b1010,      0, 0);

        applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
        checkOutput("reset", 1'b0, 4'b0000, 1'b0, 0);
`ifdef FIBRE_RD_STATS_EN
        checkStats("reset", 0, 0);
`endif

        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, AW'(a), preVal(a));
        end
        checkOutput("preload", 1'b0, 4'b0000, 1'b0, 0);

        for (int i = 0; i < 26; i++) begin
            applyStimulus(tbl[i].r, tbl[i].re, tbl[i].ra, tbl[i].we, tbl[i].wa, tbl[i].wd);
            checkOutput($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ei);
        end

        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 63) == 0);
            re = ($urandom_range(0, 3) != 0);
            ra = AW'($urandom_range(0, 255));
            we = ($urandom_range(0, 2) == 0);
            wa = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) wa = ra;
            wd = TS'($urandom);
`ifdef FIBRE_RD_STATS_EN
            stat_clr = ($urandom_range(0, 99) == 0);
`endif
            applyStimulus(r, re, ra, we, wa, wd);
            checkOutput("rand", m_valid, m_data, m_oob, m_inflight);
`ifdef FIBRE_RD_STATS_EN
            checkStats("rand", m_reads, m_oobs);
`endif
        end

`ifdef FIBRE_RD_STATS_EN
        begin
            int addrs[10] = '{1, 2, 200, 3, 250, 4, 255, 5, 6, 7};
            stat_clr = 1'b0;
            applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
            for (int i = 0; i < 10; i++) begin
                applyStimulus(1'b0, 1'b1, AW'(addrs[i]), 1'b0, '0, '0);
            end
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
            checkStats("ten_reads", 10, 3);
            stat_clr = 1'b1;
            applyStimulus(1'b0, 1'b1, 8'd5, 1'b0, '0, '0);
            stat_clr = 1'b0;
            checkStats("stat_clr", 0, 0);
            applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
            checkStats("after_clr", m_reads, m_oobs);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
